// File: rtl/proc_ctrl_fsm_if.sv
// Control bundle between proc_ctrl_fsm (master) and the datapath (slave).
// Carries run gating, instruction/flag inputs, datapath enables, selects and status.
interface proc_ctrl_fsm_if #(
   parameter int IW     = 17,
   parameter int PERF_W = 16
);
   logic              run;
   logic [IW-1:0]     instr;
   logic              alu_zero;
   logic              pc_we;
   logic              pc_src;
   logic              ir_we;
   logic              mem_addr_sel;
   logic              mem_we;
   logic              dr_we;
   logic              rf_we;
   logic              wb_sel;
   logic              srcb_sel;
   logic [3:0]        alu_op;
   logic [2:0]        state;
   logic              halted;
   logic              illegal;
   logic [PERF_W-1:0] instret;

   modport master (
      input  run, instr, alu_zero,
      output pc_we, pc_src, ir_we, mem_addr_sel, mem_we, dr_we, rf_we, wb_sel,
             srcb_sel, alu_op, state, halted, illegal, instret
   );

   modport slave (
      output run, instr, alu_zero,
      input  pc_we, pc_src, ir_we, mem_addr_sel, mem_we, dr_we, rf_we, wb_sel,
             srcb_sel, alu_op, state, halted, illegal, instret
   );
endinterface

// File: rtl/proc_ctrl_fsm.sv
// Multi-cycle control FSM (fetch/decode/exec/mem/wb) for the 17-bit datapath; 2-5 cycles per instruction.
// Enables decode combinationally from state/opcode/alu_zero; PROC_CTRL_PERF_CNT_EN builds the instret counter.
module proc_ctrl_fsm #(
   parameter int IW     = 17,
   parameter int PERF_W = 16
) (
   input  logic           clk,
   input  logic           reset,
   proc_ctrl_fsm_if.master ctl
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6
   } state_t;

   localparam logic [4:0] OP_NOP  = 5'h00;
   localparam logic [4:0] OP_ADD  = 5'h01;
   localparam logic [4:0] OP_XOR  = 5'h05;
   localparam logic [4:0] OP_ADDI = 5'h06;
   localparam logic [4:0] OP_LD   = 5'h08;
   localparam logic [4:0] OP_ST   = 5'h09;
   localparam logic [4:0] OP_BEQ  = 5'h0C;
   localparam logic [4:0] OP_JMP  = 5'h0D;
   localparam logic [4:0] OP_HALT = 5'h1F;

   state_t     state_q;
   state_t     fetch_next;
   logic       illegal_q;
   logic [4:0] opcode;
   logic       is_alu, is_addi, is_ld, is_st, is_beq, is_jmp, is_halt, is_nop, to_exec;
   logic       unused_instr;

   assign opcode       = ctl.instr[IW-1 -: 5];
   assign unused_instr = ^ctl.instr[IW-6:0];

   assign is_alu  = (opcode >= OP_ADD) && (opcode <= OP_XOR);
   assign is_addi = (opcode == OP_ADDI);
   assign is_ld   = (opcode == OP_LD);
   assign is_st   = (opcode == OP_ST);
   assign is_beq  = (opcode == OP_BEQ);
   assign is_jmp  = (opcode == OP_JMP);
   assign is_halt = (opcode == OP_HALT);
   assign is_nop  = (opcode == OP_NOP);
   assign to_exec = is_alu | is_addi | is_ld | is_st | is_beq | is_jmp;

   // Every return to FETCH parks in IDLE instead while run is low.
   assign fetch_next = ctl.run ? S_FETCH : S_IDLE;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         illegal_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE:   if (ctl.run) state_q <= S_FETCH;
            S_FETCH:  state_q <= S_DECODE;
            S_DECODE: begin
               if (is_halt)      state_q <= S_HALT;
               else if (to_exec) state_q <= S_EXEC;
               else begin
                  state_q <= fetch_next;
                  if (!is_nop) illegal_q <= 1'b1;
               end
            end
            S_EXEC: begin
               if (is_alu || is_addi)   state_q <= S_WB;
               else if (is_ld || is_st) state_q <= S_MEM;
               else                     state_q <= fetch_next;
            end
            S_MEM:    state_q <= is_ld ? S_WB : fetch_next;
            S_WB:     state_q <= fetch_next;
            S_HALT:   if (!ctl.run) state_q <= S_IDLE;
            default:  state_q <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      ctl.pc_we        = 1'b0;
      ctl.pc_src       = 1'b0;
      ctl.ir_we        = 1'b0;
      ctl.mem_addr_sel = 1'b0;
      ctl.mem_we       = 1'b0;
      ctl.dr_we        = 1'b0;
      ctl.rf_we        = 1'b0;
      ctl.wb_sel       = 1'b0;
      ctl.srcb_sel     = 1'b0;
      ctl.alu_op       = 4'h0;
      ctl.halted       = 1'b0;
      case (state_q)
         S_FETCH: begin
            ctl.ir_we = 1'b1;
            ctl.pc_we = 1'b1;
         end
         S_EXEC: begin
            if (is_alu) begin
               ctl.alu_op = opcode[3:0];
            end else if (is_addi || is_ld || is_st) begin
               ctl.alu_op   = 4'h1;
               ctl.srcb_sel = 1'b1;
            end else if (is_beq) begin
               ctl.alu_op = 4'h2;
               ctl.pc_src = 1'b1;
               ctl.pc_we  = ctl.alu_zero;
            end else if (is_jmp) begin
               ctl.pc_src = 1'b1;
               ctl.pc_we  = 1'b1;
            end
         end
         S_MEM: begin
            ctl.mem_addr_sel = 1'b1;
            ctl.dr_we        = is_ld;
            ctl.mem_we       = is_st;
         end
         S_WB: begin
            ctl.rf_we  = 1'b1;
            ctl.wb_sel = is_ld;
         end
         S_HALT:  ctl.halted = 1'b1;
         default: ;
      endcase
   end

   assign ctl.state   = state_q;
   assign ctl.illegal = illegal_q;

`ifdef PROC_CTRL_PERF_CNT_EN
   logic              retire;
   logic [PERF_W-1:0] instret_q;

   always_comb begin
      retire = 1'b0;
      case (state_q)
         S_DECODE: retire = !to_exec && !is_halt;
         S_EXEC:   retire = is_beq | is_jmp;
         S_MEM:    retire = is_st;
         S_WB:     retire = 1'b1;
         default:  retire = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)      instret_q <= '0;
      else if (retire) instret_q <= instret_q + {{(PERF_W-1){1'b0}}, 1'b1};
   end

   assign ctl.instret = instret_q;
`else
   assign ctl.instret = {PERF_W{1'b0}};
`endif

endmodule
